// File: rtl/cpu_cmode_ctrl.sv
// rtl/cpu_cmode_ctrl.sv - CPU clock-mode change sequencer with host/debug arbitration
module cpu_cmode_ctrl #(
    parameter int MODE_W     = 2,
    parameter int DEF_MODE   = 0,
    parameter int GATE_CYC   = 4,
    parameter int SETTLE_MAX = 64
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [MODE_W-1:0] mode_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [MODE_W-1:0] mode_b,
    output logic              ack_b,
    output logic              err,
    input  logic              lock,
    output logic [MODE_W-1:0] cmode,
    output logic              bclk_en,
    output logic              busy
);

    localparam int CMAX = (GATE_CYC > SETTLE_MAX) ? GATE_CYC : SETTLE_MAX;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0]     GATE_END   = CW'(GATE_CYC - 1);
    localparam logic [CW-1:0]     SETTLE_END = CW'(SETTLE_MAX - 1);
    localparam logic [CW-1:0]     CNT_SAT    = '1;
    localparam logic [MODE_W-1:0] DEF        = MODE_W'(DEF_MODE);

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        SWITCH,
        SETTLE,
        UNGATE,
        ACK
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [MODE_W-1:0] cmode_q, cmode_d;
    logic [MODE_W-1:0] target_q, target_d;
    logic [MODE_W-1:0] prev_q, prev_d;
    logic [MODE_W-1:0] sel_mode;
    logic              bclk_en_q, bclk_en_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              owner_q, owner_d;
    logic              to_flag_q, to_flag_d;
    logic              hi_q, hi_d;
    logic              mask_q, mask_d;
    logic              req_a_ok, req_b_ok;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmode_q   <= DEF;
            target_q  <= DEF;
            prev_q    <= DEF;
            bclk_en_q <= 1'b1;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            owner_q   <= 1'b0;
            to_flag_q <= 1'b0;
            hi_q      <= 1'b0;
            mask_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmode_q   <= cmode_d;
            target_q  <= target_d;
            prev_q    <= prev_d;
            bclk_en_q <= bclk_en_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            to_flag_q <= to_flag_d;
            hi_q      <= hi_d;
            mask_q    <= mask_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmode_d   = cmode_q;
        target_d  = target_q;
        prev_d    = prev_q;
        bclk_en_d = bclk_en_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        err_d     = 1'b0;
        owner_d   = owner_q;
        to_flag_d = to_flag_q;
        hi_d      = hi_q;
        mask_d    = 1'b0;
        cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        // The just-acked owner may still hold req for one cycle; ignore it then.
        req_a_ok  = req_a & ~(mask_q & ~owner_q);
        req_b_ok  = req_b & ~(mask_q & owner_q);
        sel_mode  = req_b_ok ? mode_b : mode_a;

        case (state_q)
            IDLE: begin
                if (req_a_ok || req_b_ok) begin
                    owner_d  = req_b_ok;
                    target_d = sel_mode;
                    prev_d   = cmode_q;
                    cnt_d    = '0;
                    if (sel_mode == cmode_q) begin
                        state_d = ACK;
                        ack_a_d = ~req_b_ok;
                        ack_b_d = req_b_ok;
                    end else begin
                        state_d   = GATE;
                        bclk_en_d = 1'b0;
                    end
                end
            end
            GATE: begin
                // The SWITCH cycle is the last of the GATE_CYC gated cycles.
                cnt_d = cnt_inc;
                if (cnt_inc >= GATE_END) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                cmode_d = target_q;
                cnt_d   = '0;
                hi_d    = 1'b0;
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_inc;
                if ((cnt_q != '0) && lock && hi_q) begin
                    state_d = UNGATE;
                    cnt_d   = '0;
                end else if (cnt_q >= SETTLE_END) begin
                    cmode_d   = prev_q;
                    to_flag_d = 1'b1;
                    state_d   = UNGATE;
                    cnt_d     = '0;
                end else begin
                    hi_d = (cnt_q != '0) && lock;
                end
            end
            UNGATE: begin
                cnt_d = cnt_inc;
                if (cnt_q >= GATE_END) begin
                    state_d   = ACK;
                    bclk_en_d = 1'b1;
                    ack_a_d   = ~owner_q;
                    ack_b_d   = owner_q;
                    err_d     = to_flag_q;
                end
            end
            ACK: begin
                to_flag_d = 1'b0;
                mask_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign cmode   = cmode_q;
    assign bclk_en = bclk_en_q;
    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_cpu_cmode_ctrl.sv
// tb/tb_cpu_cmode_ctrl.sv - directed self-checking bench for cpu_cmode_ctrl
module tb_cpu_cmode_ctrl;

    logic       sysclk;
    logic       rst;
    logic       req_a;
    logic [1:0] mode_a;
    logic       ack_a;
    logic       req_b;
    logic [1:0] mode_b;
    logic       ack_b;
    logic       err;
    logic       lock;
    logic [1:0] cmode;
    logic       bclk_en;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cnt_a, cnt_b, cyc_a, cyc_b, acks;

    cpu_cmode_ctrl dut (
        .sysclk  (sysclk),
        .rst     (rst),
        .req_a   (req_a),
        .mode_a  (mode_a),
        .ack_a   (ack_a),
        .req_b   (req_b),
        .mode_b  (mode_b),
        .ack_b   (ack_b),
        .err     (err),
        .lock    (lock),
        .cmode   (cmode),
        .bclk_en (bclk_en),
        .busy    (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0; lock = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_cmode", 32'(cmode), 32'd0);
        chk("rst_bclk", 32'(bclk_en), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'({ack_a, ack_b, err}), 32'd0);

        // Asynchronous reset while in SETTLE
        mode_a = 2'd2; req_a = 1'b1;
        for (int n = 1; n <= 7; n++) tick();
        chk("mid_cmode", 32'(cmode), 32'd2);
        chk("mid_bclk", 32'(bclk_en), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cmode", 32'(cmode), 32'd0);
        chk("arst_bclk", 32'(bclk_en), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        req_a = 1'b0;
        tick();
        rst = 1'b0;
        acks = 0;
        for (int n = 1; n <= 15; n++) begin
            tick();
            if (ack_a || ack_b) acks++;
        end
        chk("arst_noack", 32'(acks), 32'd0);
        chk("arst_cmode_after", 32'(cmode), 32'd0);

        // Nominal change 0 -> 2 with lock high; req held one cycle past ack
        lock = 1'b1; mode_a = 2'd2; req_a = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            tick();
            chk("nom_ack", 32'(ack_a), 32'(n == 12));
            if (n <= 11) chk("nom_bclk_low", 32'(bclk_en), 32'd0);
            if (n <= 4) chk("nom_cmode_old", 32'(cmode), 32'd0);
            if (n >= 5) chk("nom_cmode_new", 32'(cmode), 32'd2);
            if (n == 12) begin
                chk("nom_bclk_ack", 32'(bclk_en), 32'd1);
                chk("nom_err", 32'(err), 32'd0);
            end
            if (n == 13) req_a = 1'b0;
            if (n >= 14) chk("nom_masked", 32'(busy), 32'd0);
        end

        // Simultaneous requests: B first, then A
        mode_a = 2'd1; mode_b = 2'd3; req_a = 1'b1; req_b = 1'b1;
        cnt_a = 0; cnt_b = 0; cyc_a = 0; cyc_b = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (ack_b) begin cnt_b++; cyc_b = n; req_b = 1'b0; end
            if (ack_a) begin cnt_a++; cyc_a = n; req_a = 1'b0; end
            if (n == 12) chk("sim_cmode_b", 32'(cmode), 32'd3);
            if (n == 13) chk("sim_bclk_gap", 32'(bclk_en), 32'd1);
            if (n == 25) chk("sim_cmode_a", 32'(cmode), 32'd1);
        end
        chk("sim_cnt_b", 32'(cnt_b), 32'd1);
        chk("sim_cyc_b", 32'(cyc_b), 32'd12);
        chk("sim_cnt_a", 32'(cnt_a), 32'd1);
        chk("sim_cyc_a", 32'(cyc_a), 32'd25);

        // Same-mode request: no gating
        mode_b = 2'd1; req_b = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk("same_ack", 32'(ack_b), 32'(n == 1));
            chk("same_bclk", 32'(bclk_en), 32'd1);
            chk("same_cmode", 32'(cmode), 32'd1);
            if (ack_b) req_b = 1'b0;
        end

        // Lock never arrives: revert to 1
        lock = 1'b0; mode_a = 2'd2; req_a = 1'b1;
        for (int n = 1; n <= 75; n++) begin
            tick();
            chk("to_ack", 32'(ack_a), 32'(n == 73));
            chk("to_err", 32'(err), 32'(n == 73));
            if (n == 68) chk("to_cmode_pre", 32'(cmode), 32'd2);
            if (n == 69) chk("to_cmode_rev", 32'(cmode), 32'd1);
            if (n == 72) chk("to_bclk_low", 32'(bclk_en), 32'd0);
            if (n == 73) chk("to_bclk_on", 32'(bclk_en), 32'd1);
            if (ack_a) req_a = 1'b0;
        end

        // Glitching lock: SETTLE cycles S0..S4 see 1(ignored),1,0,1,1
        mode_a = 2'd3; req_a = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk("gl_ack", 32'(ack_a), 32'(n == 14));
            if (n <= 13) chk("gl_bclk_low", 32'(bclk_en), 32'd0);
            if (n == 14) begin
                chk("gl_bclk_on", 32'(bclk_en), 32'd1);
                chk("gl_cmode", 32'(cmode), 32'd3);
                chk("gl_err", 32'(err), 32'd0);
            end
            if (ack_a) req_a = 1'b0;
            case (n)
                5, 6, 8, 9: lock = 1'b1;
                default:    lock = 1'b0;
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_cmode_ctrl.md
Name: cpu_cmode_ctrl

Overview:
Sequences clock-mode changes for the CHIP CPU instance: it owns the `cmode` and `bclko` gate-enable inputs.
It arbitrates mode-change requests from two requesters: host (A) and debug (B).
Each granted change follows a fixed sequence: gate bclko, switch cmode, wait for lock, ungate.
If lock never arrives, it falls back to the previous mode.

Parameters:
MODE_W, 2, width of cmode and of requested modes
DEF_MODE, 0, cmode value driven from reset
GATE_CYC, 4, cycles bclk_en is held low before cmode changes and before it is re-enabled (min 1)
SETTLE_MAX, 64, cycles allowed in SETTLE for lock before timeout (min 2)

Ports:
sysclk  in  1  single clock, all state on posedge
rst  in  1  asynchronous, active-high reset
req_a  in  1  host mode-change request, level, held until ack_a
mode_a  in  MODE_W  host requested mode, stable while req_a high
ack_a  out  1  one-cycle completion pulse to host
req_b  in  1  debug mode-change request, level, held until ack_b
mode_b  in  MODE_W  debug requested mode, stable while req_b high
ack_b  out  1  one-cycle completion pulse to debug
err  out  1  one-cycle pulse coincident with ack_x when the change timed out
lock  in  1  CPU clock-lock status, synchronous to sysclk
cmode  out  MODE_W  registered mode to CPU
bclk_en  out  1  registered bclko gate enable, 1 = running
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (asynchronous, immediate, also mid-sequence): cmode=DEF_MODE, bclk_en=1, ack_a=ack_b=0, err=0, busy=0, state=IDLE, counters=0, prev/target regs=DEF_MODE.
- Outputs are registered; no combinational path from inputs to outputs.
- Arbitration happens in IDLE only. B has fixed priority over A. A request arriving during a sequence waits; it is never dropped.
- Grant latches target=mode_x, prev=cmode and owner. Later changes on mode_x are ignored.
- Handshake:
  - ack_x is a single-cycle pulse.
  - The requester deasserts req_x on the cycle after ack.
  - The FSM spends one cycle in ACK and one in IDLE. The owner's req is masked in the cycle immediately after ACK, so a late-dropped req is not re-granted.
- FSM states: IDLE, GATE, SWITCH, SETTLE, UNGATE, ACK.
  - IDLE:
    - granted req with target==cmode -> ACK (no gating, ack 1 cycle after the grant cycle).
    - other granted req -> GATE, bclk_en<=0, cnt<=0.
  - GATE: cnt counts to GATE_CYC-1, then -> SWITCH.
  - SWITCH: one cycle; cmode<=target; cnt<=0; -> SETTLE.
  - SETTLE:
    - The first SETTLE cycle ignores lock, since lock may still reflect the old mode.
    - After that, lock sampled high on 2 consecutive cycles -> UNGATE, cnt<=0. A lock low resets the consecutive count.
    - cnt reaching SETTLE_MAX-1 without success -> timeout: cmode<=prev, to_flag<=1, -> UNGATE.
  - UNGATE:
    - bclk_en stays 0 for GATE_CYC cycles.
    - On the transition to ACK, bclk_en<=1.
    - After a timeout, this covers the revert settling; lock is not rechecked.
  - ACK: ack_owner=1, err=to_flag, to_flag<=0; -> IDLE.
- Nominal latency, grant cycle to ack: 1 + GATE_CYC + 1 + (2..3 settle) + GATE_CYC. Default 12 cycles with lock already high.
- bclk_en is low continuously from the cycle after the grant until ACK is entered. cmode never changes while bclk_en=1.
- Simultaneous req_a and req_b in IDLE: B is served, then A (A still held) on the IDLE following B's ACK.
- Counters are sized clog2(max(GATE_CYC,SETTLE_MAX))+1 and saturate rather than wrap.

Test Plan:
- After reset, cmode=0 and bclk_en=1. Pulse rst mid-SETTLE -> outputs return to reset values the same cycle; no ack afterwards.
- req_a, mode_a=2, lock held 1 -> bclk_en low 4 cycles, cmode=2, ack_a at grant+12, err=0, bclk_en=1 the same cycle as ack.
- req_a and req_b asserted on the same cycle (mode_a=1, mode_b=3) -> cmode=3, ack_b first; then cmode=1, ack_a; exactly one ack each.
- req_b with mode_b equal to current cmode -> ack_b 1 cycle after the grant, bclk_en stays 1, no cmode change.
- req_a mode 2, lock held 0 -> at SETTLE cycle 64 cmode reverts to the previous value; ack_a and err pulse together; bclk_en restored.
- lock toggles 1,0,1,1 in SETTLE -> success only after the final consecutive pair; a glitching lock never produces an early UNGATE.
